// File: rtl/t_pattern_gen_if.sv
// Control/status bundle between a pattern programmer and t_pattern_gen.
// master drives configuration and commands; slave is the generator.
interface t_pattern_gen_if #(
    parameter int PAT_W = 8,
    parameter int DIV_W = 8,
    parameter int RPT_W = 4
);
    localparam int IDX_W = $clog2(PAT_W);

    logic              load;
    logic [PAT_W-1:0]  pattern;
    logic [DIV_W-1:0]  divisor;
    logic [RPT_W-1:0]  repeat_n;
    logic              start;
    logic              abort;
    logic              t;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  bit_idx;
    logic [15:0]       ones_cnt;

    modport master (
        output load, pattern, divisor, repeat_n, start, abort,
        input  t, busy, done, bit_idx, ones_cnt
    );

    modport slave (
        input  load, pattern, divisor, repeat_n, start, abort,
        output t, busy, done, bit_idx, ones_cnt
    );
endinterface

// File: rtl/t_pattern_gen.sv
// Serialises a loaded pattern LSB-first onto t, each bit held divisor+1 cycles, pattern replayed repeat_n+1 times.
// Latency: t/busy valid from the edge that samples start; done pulses one cycle after the last busy cycle.
// No backpressure: load/start are only honoured in IDLE, abort stops a run at the sampling edge.
module t_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int DIV_W = 8,
    parameter int RPT_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    t_pattern_gen_if.slave bus
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [PAT_W-1:0]  pat_reg, pat_nxt;
    logic [DIV_W-1:0]  div_reg, div_nxt;
    logic [RPT_W-1:0]  rep_reg, rep_nxt;
    logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
    logic [RPT_W-1:0]  rep_cnt, rep_cnt_nxt;
    logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
    logic              t_q, t_nxt;
    logic [15:0]       ones_cnt, ones_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pat_reg  <= '0;
            div_reg  <= '0;
            rep_reg  <= '0;
            div_cnt  <= '0;
            rep_cnt  <= '0;
            bit_idx  <= '0;
            t_q      <= 1'b0;
            ones_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pat_reg  <= pat_nxt;
            div_reg  <= div_nxt;
            rep_reg  <= rep_nxt;
            div_cnt  <= div_cnt_nxt;
            rep_cnt  <= rep_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            t_q      <= t_nxt;
            ones_cnt <= ones_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pat_nxt     = pat_reg;
        div_nxt     = div_reg;
        rep_nxt     = rep_reg;
        div_cnt_nxt = div_cnt;
        rep_cnt_nxt = rep_cnt;
        bit_idx_nxt = bit_idx;
        t_nxt       = 1'b0;
        ones_nxt    = ones_cnt;

        unique case (state)
            IDLE: begin
                if (bus.load) begin
                    pat_nxt = bus.pattern;
                    div_nxt = bus.divisor;
                    rep_nxt = bus.repeat_n;
                end
                if (bus.start) begin
                    state_nxt   = RUN;
                    div_cnt_nxt = '0;
                    rep_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    ones_nxt    = '0;
                    // Same-cycle load must already steer the first bit.
                    t_nxt       = pat_nxt[0];
                end
            end
            RUN: begin
                // The cycle ending at this edge counts, including an abort edge.
                if (t_q && ones_cnt != 16'hFFFF)
                    ones_nxt = ones_cnt + 16'd1;
                if (bus.abort) begin
                    state_nxt   = IDLE;
                    bit_idx_nxt = '0;
                end else if (div_cnt == div_reg) begin
                    div_cnt_nxt = '0;
                    if (bit_idx == LAST_IDX) begin
                        bit_idx_nxt = '0;
                        if (rep_cnt == rep_reg)
                            state_nxt = DONE;
                        else
                            rep_cnt_nxt = rep_cnt + RPT_W'(1);
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
                if (state_nxt == RUN)
                    t_nxt = pat_reg[bit_idx_nxt];
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.t        = t_q;
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.bit_idx  = bit_idx;
    assign bus.ones_cnt = ones_cnt;

endmodule

// File: tb/tb_t_pattern_gen.sv
// Bench for t_pattern_gen: table-driven runs, hand-written abort/reset sequences and randomized runs
// checked cycle by cycle against an expected t sequence expanded from pattern/divisor/repeat_n.
module tb_t_pattern_gen;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Shadow register model: what the generator should replay on a start without load.
    logic [7:0] m_pat;
    logic [7:0] m_div;
    logic [3:0] m_rep;

    t_pattern_gen_if #(.PAT_W(8), .DIV_W(8), .RPT_W(4)) bus ();

    t_pattern_gen #(.PAT_W(8), .DIV_W(8), .RPT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.load     = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.pattern  = '0;
        bus.divisor  = '0;
        bus.repeat_n = '0;
    endtask

    task automatic drive_noise();
        bus.load     = 1'($urandom_range(0, 1));
        bus.start    = 1'($urandom_range(0, 1));
        bus.pattern  = 8'($urandom);
        bus.divisor  = 8'($urandom);
        bus.repeat_n = 4'($urandom);
    endtask

    // One complete run. abort_at = run cycle during which abort is driven (negative: none).
    task automatic do_run(input logic [7:0] p, input logic [7:0] d, input logic [3:0] r,
                          input bit do_load, input bit same, input int abort_at, input bit noise,
                          output int len_o, output int ones_o);
        bit seq[$];
        int idxq[$];
        int ones;
        bit aborted;
        if (do_load && !same) begin
            bus.load = 1'b1; bus.pattern = p; bus.divisor = d; bus.repeat_n = r;
            step();
            clear_inputs();
        end
        if (do_load) begin
            m_pat = p; m_div = d; m_rep = r;
        end
        if (do_load && same) begin
            bus.load = 1'b1; bus.pattern = p; bus.divisor = d; bus.repeat_n = r;
        end
        bus.start = 1'b1;
        for (int rr = 0; rr <= int'(m_rep); rr++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c <= int'(m_div); c++) begin
                    seq.push_back(m_pat[b]);
                    idxq.push_back(b);
                end
        step();
        clear_inputs();
        ones = 0;
        aborted = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            chk("run_t", 32'(bus.t), 32'(seq[i]));
            chk("run_busy", 32'(bus.busy), 32'd1);
            chk("run_bit_idx", 32'(bus.bit_idx), 32'(idxq[i]));
            chk("run_done", 32'(bus.done), 32'd0);
            ones += int'(seq[i]);
            if (noise) drive_noise();
            if (i == abort_at) bus.abort = 1'b1;
            step();
            clear_inputs();
            if (i == abort_at) begin
                chk("abort_busy", 32'(bus.busy), 32'd0);
                chk("abort_t", 32'(bus.t), 32'd0);
                chk("abort_done", 32'(bus.done), 32'd0);
                chk("abort_ones", 32'(bus.ones_cnt), 32'(ones));
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            chk("end_done", 32'(bus.done), 32'd1);
            chk("end_busy", 32'(bus.busy), 32'd0);
            chk("end_t", 32'(bus.t), 32'd0);
            chk("end_ones", 32'(bus.ones_cnt), 32'(ones));
            if (noise) begin
                bus.abort = 1'($urandom_range(0, 1));
            end
            step();
            clear_inputs();
        end
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_bit_idx", 32'(bus.bit_idx), 32'd0);
        chk("idle_ones_hold", 32'(bus.ones_cnt), 32'(ones));
        len_o  = aborted ? -1 : int'(seq.size());
        ones_o = ones;
    endtask

    typedef struct {
        logic [7:0] pat;
        logic [7:0] div;
        logic [3:0] rep;
        bit         same;
        int         exp_len;
        int         exp_ones;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int len, ones;
        checks = 0;
        failures = 0;
        m_pat = '0; m_div = '0; m_rep = '0;
        clear_inputs();

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk("rst_t", 32'(bus.t), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ones", 32'(bus.ones_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // Start with nothing loaded: eight cycles of t=0 then done.
        do_run('0, '0, '0, 1'b0, 1'b0, -1, 1'b0, len, ones);
        chk("noload_len", 32'(len), 32'd8);
        chk("noload_ones", 32'(ones), 32'd0);

        vecs[0] = '{pat: 8'b0000_0110, div: 8'd0, rep: 4'd0, same: 1'b0, exp_len: 8,  exp_ones: 2};
        vecs[1] = '{pat: 8'hA5,        div: 8'd2, rep: 4'd1, same: 1'b0, exp_len: 48, exp_ones: 24};
        vecs[2] = '{pat: 8'hFF,        div: 8'd1, rep: 4'd0, same: 1'b1, exp_len: 16, exp_ones: 16};
        for (int v = 0; v < 3; v++) begin
            do_run(vecs[v].pat, vecs[v].div, vecs[v].rep, 1'b1, vecs[v].same, -1, 1'b0, len, ones);
            chk($sformatf("vec%0d_len", v), 32'(len), 32'(vecs[v].exp_len));
            chk($sformatf("vec%0d_ones", v), 32'(bus.ones_cnt), 32'(vecs[v].exp_ones));
        end
        chk("q_parity_06", 32'(vecs[0].exp_ones % 2), 32'd0);

        // Abort during the fifth run cycle, with load/start noise throughout.
        do_run(8'hFF, 8'd3, 4'd0, 1'b1, 1'b0, 4, 1'b1, len, ones);
        chk("abort_ones5", 32'(bus.ones_cnt), 32'd5);
        step();
        chk("abort_no_late_done", 32'(bus.done), 32'd0);
        // Shadow must still hold FF/div3 despite the noise.
        do_run('0, '0, '0, 1'b0, 1'b0, -1, 1'b0, len, ones);
        chk("shadow_len", 32'(len), 32'd32);
        chk("shadow_ones", 32'(ones), 32'd32);

        // Asynchronous reset mid-run.
        bus.start = 1'b1;
        step();
        clear_inputs();
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_t", 32'(bus.t), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_bit_idx", 32'(bus.bit_idx), 32'd0);
        chk("arst_ones", 32'(bus.ones_cnt), 32'd0);
        step();
        chk("arst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        m_pat = '0; m_div = '0; m_rep = '0;
        step();
        do_run('0, '0, '0, 1'b0, 1'b0, -1, 1'b0, len, ones);
        chk("post_rst_len", 32'(len), 32'd8);
        chk("post_rst_ones", 32'(bus.ones_cnt), 32'd0);

        // Randomized runs, some aborted, with command noise during the run.
        for (int n = 0; n < 16; n++) begin
            logic [7:0] p;
            logic [7:0] d;
            logic [3:0] r;
            int ab;
            p  = 8'($urandom);
            d  = 8'($urandom_range(0, 3));
            r  = 4'($urandom_range(0, 2));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            do_run(p, d, r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   ab, 1'b1, len, ones);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
